// File: rtl/e_mul_unit_pkg.sv
// Shared constants and types for the RV32M iterative multiplier.
package e_mul_unit_pkg;

  // Default ROB tag width used across the execute stage.
  localparam int ROB_ENTRY_WIDTH_DEFAULT = 6;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic s1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic s2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH);
  endfunction

endpackage

// File: rtl/e_mul_unit_mul_iter_core.sv
// Radix-2 shift-add multiplier on unsigned magnitudes. A start pulse loads
// the operands; one partial product is added per clock. last_step is high on
// the cycle whose edge performs the final step, and product is the
// accumulator value that edge writes, so the caller can capture it directly.
module mul_iter_core #(
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   mag_a,
  input  logic [WORD_SIZE-1:0]   mag_b,
  output logic                   last_step,
  output logic [2*WORD_SIZE-1:0] product
);

  localparam int CW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_SIZE - 1);

  logic [2*WORD_SIZE-1:0] mcand_reg;
  logic [2*WORD_SIZE-1:0] acc_reg;
  logic [WORD_SIZE-1:0]   mplier_reg;
  logic [CW-1:0]          count_reg;
  logic                   busy_reg;
  logic [2*WORD_SIZE-1:0] addend;
  logic [2*WORD_SIZE-1:0] acc_next;

  // Partial product: multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < 2 * WORD_SIZE; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next  = acc_reg + addend;
  assign last_step = busy_reg && (count_reg == LAST_COUNT);
  assign product   = acc_next;

  // Load on start, otherwise advance one shift-add step while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WORD_SIZE{1'b0}}, mag_a};
      acc_reg    <= '0;
      mplier_reg <= mag_b;
      count_reg  <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (last_step) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/e_mul_unit.sv
// Execute-stage RV32M MUL-group unit: accepts one instruction from the
// decode/execute register, stalls it while iterating, and holds one tagged
// result until downstream takes it.
module e_mul_unit
  import e_mul_unit_pkg::*;
#(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [6:0]                 opcode,
  input  logic [6:0]                 funct7,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       s1,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  input  logic                       stall_in,
  output logic                       stall_out,
  output logic                       valid_out,
  output logic [WORD_SIZE-1:0]       result_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out
);

  mul_state_e                 state_reg;
  mul_state_e                 state_next;
  logic [2:0]                 f3_reg;
  logic                       neg_reg;
  logic [ROB_ENTRY_WIDTH-1:0] rob_reg;
  logic [WORD_SIZE-1:0]       result_reg;
  logic [ROB_ENTRY_WIDTH-1:0] rob_out_reg;

  logic                       accept;
  logic                       s1_neg;
  logic                       s2_neg;
  logic [WORD_SIZE-1:0]       mag_a;
  logic [WORD_SIZE-1:0]       mag_b;
  logic                       core_last;
  logic [2*WORD_SIZE-1:0]     core_product;
  logic [2*WORD_SIZE-1:0]     signed_product;

  // Decode the incoming instruction and convert operands to magnitudes.
  always_comb begin
    accept = valid_in && (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV)
             && !funct3[2] && (state_reg == IDLE);
    s1_neg = s1_is_signed(funct3) && s1[WORD_SIZE-1];
    s2_neg = s2_is_signed(funct3) && s2[WORD_SIZE-1];
    mag_a  = s1_neg ? -s1 : s1;
    mag_b  = s2_neg ? -s2 : s2;
  end

  mul_iter_core #(
    .WORD_SIZE(WORD_SIZE)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .last_step(core_last),
    .product  (core_product)
  );

  // Restore the sign of the final product before the word is selected.
  assign signed_product = neg_reg ? -core_product : core_product;

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    valid_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        stall_out = 1'b1;
        if (core_last) state_next = DONE;
      end
      DONE: begin
        valid_out = 1'b1;
        stall_out = stall_in;
        if (!stall_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, latched instruction fields and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      f3_reg      <= '0;
      neg_reg     <= 1'b0;
      rob_reg     <= '0;
      result_reg  <= '0;
      rob_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        f3_reg  <= funct3;
        neg_reg <= s1_neg ^ s2_neg;
        rob_reg <= rob_id;
      end
      if (state_reg == BUSY && core_last) begin
        result_reg  <= (f3_reg == F3_MUL) ? signed_product[WORD_SIZE-1:0]
                                          : signed_product[2*WORD_SIZE-1:WORD_SIZE];
        rob_out_reg <= rob_reg;
      end
    end
  end

  assign result_out = result_reg;
  assign rob_id_out = rob_out_reg;

endmodule

// File: tb/tb_e_mul_unit.sv
// Self-checking bench for e_mul_unit: table of operations with a result
// scoreboard, plus directed sequences for stall hold, reset and non-MUL input.
module tb_e_mul_unit;
  import e_mul_unit_pkg::*;

  localparam int W    = 32;
  localparam int ROBW = ROB_ENTRY_WIDTH_DEFAULT;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            valid_in = 1'b0;
  logic [6:0]      opcode = '0;
  logic [6:0]      funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [W-1:0]    s1 = '0;
  logic [W-1:0]    s2 = '0;
  logic [ROBW-1:0] rob_id = '0;
  logic            stall_in = 1'b0;
  logic            stall_out;
  logic            valid_out;
  logic [W-1:0]    result_out;
  logic [ROBW-1:0] rob_id_out;

  e_mul_unit #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(ROBW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .opcode    (opcode),
    .funct7    (funct7),
    .funct3    (funct3),
    .s1        (s1),
    .s2        (s2),
    .rob_id    (rob_id),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .valid_out (valid_out),
    .result_out(result_out),
    .rob_id_out(rob_id_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      f3;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [ROBW-1:0] rob;
    logic [W-1:0]    exp;
  } vec_t;

  typedef struct {
    logic [W-1:0]    res;
    logic [ROBW-1:0] rob;
  } sb_t;

  vec_t vecs[$];
  sb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  function automatic vec_t mkvec(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [ROBW-1:0] rob,
                                 input logic [W-1:0] exp);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rob = rob; v.exp = exp;
    return v;
  endfunction

  // Reference product using full-width 64-bit arithmetic on extended operands.
  function automatic logic [W-1:0] ref_mul(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == F3_MULH || f3 == F3_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f3 == F3_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f3 == F3_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a MUL-group instruction in IDLE; the next edge accepts it.
  task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [ROBW-1:0] rob, input logic [W-1:0] exp);
    sb_t e;
    valid_in = 1'b1; opcode = OPCODE_OP; funct7 = FUNCT7_MULDIV;
    funct3 = f3; s1 = a; s2 = b; rob_id = rob;
    @(posedge clk); #1;
    e.res = exp; e.rob = rob;
    exp_q.push_back(e);
    chk("accept_stall", {31'b0, stall_out}, 32'd1);
    valid_in = 1'b0;
  endtask

  // Count edges until valid_out, scrambling the inputs while busy.
  task automatic wait_done(output int lat);
    int busy_stall;
    lat = 0;
    busy_stall = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (valid_out) break;
      if (stall_out) busy_stall++;
      if (lat > 100) begin
        checks++; errors++;
        $display("FAIL timeout: no valid_out after %0d edges, expected %0d", lat, W);
        break;
      end
      valid_in = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 3));
      s1 = $urandom; s2 = $urandom; rob_id = ROBW'($urandom);
    end
    valid_in = 1'b0;
    chk("latency", lat, W);
    chk("busy_stall_cycles", busy_stall, W - 1);
  endtask

  task automatic check_result();
    sb_t e;
    chk("valid_out_done", {31'b0, valid_out}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: result %h with no expected entry, expected queued op", result_out);
    end else begin
      e = exp_q.pop_front();
      chk("result_out", result_out, e.res);
      chk("rob_id_out", {{(W-ROBW){1'b0}}, rob_id_out}, {{(W-ROBW){1'b0}}, e.rob});
    end
  endtask

  task automatic run_full(input vec_t v);
    int lat;
    start_op(v.f3, v.a, v.b, v.rob, v.exp);
    wait_done(lat);
    check_result();
    chk("retire_stall", {31'b0, stall_out}, 32'd0);
    $display("txn %0d: f3=%0d s1=%h s2=%h rob=%0d -> result=%h rob_out=%0d latency=%0d",
             txn, v.f3, v.a, v.b, v.rob, result_out, rob_id_out, lat);
    txn++;
    @(posedge clk); #1;
    chk("valid_after_retire", {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t v;

    vecs.push_back(mkvec(F3_MUL,    32'd7,        32'd6,        6'd3,  32'd42));
    vecs.push_back(mkvec(F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 6'd4,  32'h00000001));
    vecs.push_back(mkvec(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5,  32'h00000000));
    vecs.push_back(mkvec(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd6,  32'hFFFFFFFE));
    vecs.push_back(mkvec(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd7,  32'hFFFFFFFF));
    vecs.push_back(mkvec(F3_MULH,   32'h80000000, 32'h80000000, 6'd8,  32'h40000000));
    vecs.push_back(mkvec(F3_MUL,    32'h80000000, 32'h80000000, 6'd9,  32'h00000000));
    vecs.push_back(mkvec(F3_MULH,   32'h80000000, 32'h7FFFFFFF, 6'd10, 32'hC0000000));
    vecs.push_back(mkvec(F3_MULH,   32'hFFFFFFF9, 32'd6,        6'd11, 32'hFFFFFFFF));
    vecs.push_back(mkvec(F3_MUL,    32'hFFFFFFF9, 32'd6,        6'd12, 32'hFFFFFFD6));
    vecs.push_back(mkvec(F3_MULHU,  32'h80000000, 32'd2,        6'd13, 32'h00000001));
    vecs.push_back(mkvec(F3_MUL,    32'd0,        32'h12345678, 6'd14, 32'h00000000));
    vecs.push_back(mkvec(F3_MULHSU, 32'h00000000, 32'hFFFFFFFF, 6'd15, 32'h00000000));
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f3;
      logic [W-1:0] a, b;
      f3 = 3'(i);
      a = $urandom; b = $urandom;
      vecs.push_back(mkvec(f3, a, b, ROBW'(20 + i), ref_mul(f3, a, b)));
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid_out",  {31'b0, valid_out}, 32'd0);
    chk("reset_stall_out",  {31'b0, stall_out}, 32'd0);
    chk("reset_result_out", result_out, 32'd0);
    chk("reset_rob_id_out", {{(W-ROBW){1'b0}}, rob_id_out}, 32'd0);

    foreach (vecs[i]) run_full(vecs[i]);

    // Downstream stall held for three cycles in DONE, then back-to-back op.
    stall_in = 1'b1;
    start_op(F3_MUL, 32'd9, 32'd7, 6'd12, 32'd63);
    wait_done(lat);
    check_result();
    chk("done_stall_out", {31'b0, stall_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid",  {31'b0, valid_out}, 32'd1);
      chk("hold_result", result_out, 32'd63);
      chk("hold_rob",    {{(W-ROBW){1'b0}}, rob_id_out}, 32'd12);
      chk("hold_stall",  {31'b0, stall_out}, 32'd1);
    end
    $display("txn %0d: stalled MUL 9*7 held result=%h rob_out=%0d for 3 cycles",
             txn, result_out, rob_id_out);
    txn++;
    stall_in = 1'b0;
    #1;
    chk("release_stall", {31'b0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("release_valid", {31'b0, valid_out}, 32'd0);
    run_full(mkvec(F3_MUL, 32'd5, 32'd5, 6'd1, 32'd25));

    // Reset in the middle of an operation.
    start_op(F3_MUL, 32'd100, 32'd100, 6'd7, 32'd10000);
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_back());
    chk("midreset_valid",  {31'b0, valid_out}, 32'd0);
    chk("midreset_stall",  {31'b0, stall_out}, 32'd0);
    chk("midreset_result", result_out, 32'd0);
    chk("midreset_rob",    {{(W-ROBW){1'b0}}, rob_id_out}, 32'd0);
    $display("txn %0d: reset at iteration 10 -> valid=%0d stall=%0d result=%h",
             txn, valid_out, stall_out, result_out);
    txn++;
    reset = 1'b0;
    run_full(mkvec(F3_MUL, 32'd3, 32'd4, 6'd9, 32'd12));

    // Non-MUL instructions must be ignored.
    valid_in = 1'b1; opcode = OPCODE_OP; funct7 = 7'b0000000; funct3 = 3'b000;
    s1 = 32'd3; s2 = 32'd4; rob_id = 6'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("add_stall", {31'b0, stall_out}, 32'd0);
      chk("add_valid", {31'b0, valid_out}, 32'd0);
    end
    funct7 = FUNCT7_MULDIV; funct3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("div_stall", {31'b0, stall_out}, 32'd0);
      chk("div_valid", {31'b0, valid_out}, 32'd0);
    end
    opcode = 7'b0010011; funct3 = 3'b000;
    @(posedge clk); #1;
    chk("opimm_stall", {31'b0, stall_out}, 32'd0);
    valid_in = 1'b0;
    $display("txn %0d: non-MUL instructions ignored, stall=%0d valid=%0d",
             txn, stall_out, valid_out);
    txn++;

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
